// File: rtl/dsp_sequencer.sv
// dsp_sequencer
//   Per-sample program sequencer for the mixer DSP core. A sample_tick starts
//   one pass over the instruction ROM. Each fetched 36-bit word is decoded into
//   registered read addresses and an opcode for the ALU. The write address and
//   strobe follow WB_LAT cycles later. A HALT word ends the program early, and
//   a tick that arrives while a frame is in progress sets a sticky overrun flag.
//
// Ports
//   clk, rst_n       clock, asynchronous active-low reset
//   sample_tick      one-cycle frame start strobe
//   addrI / dataI    instruction ROM address out / ROM word in (1-cycle latency)
//   addrA, addrB     registered read addresses
//   opcode           ALU opcode, aligned with addrA/addrB
//   issue_valid      addrA/addrB/opcode carry a live instruction
//   addrW, writeEn   delayed write address and strobe
//   busy             frame in progress
//   frame_done       one-cycle pulse when the frame has fully drained
//   overrun          sticky; set by a tick outside IDLE
//   overrun_clr      clears overrun (a simultaneous set wins)
module dsp_sequencer #(
    parameter int IAW      = 9,
    parameter int IWW      = 36,
    parameter int DAW      = 10,
    parameter int PROG_LEN = 512,
    parameter int WB_LAT   = 3
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           sample_tick,
    output logic [IAW-1:0] addrI,
    input  logic [IWW-1:0] dataI,
    output logic [DAW-1:0] addrA,
    output logic [DAW-1:0] addrB,
    output logic [5:0]     opcode,
    output logic           issue_valid,
    output logic [DAW-1:0] addrW,
    output logic           writeEn,
    output logic           busy,
    output logic           frame_done,
    output logic           overrun,
    input  logic           overrun_clr
);

    localparam logic [IAW-1:0] LAST   = IAW'(PROG_LEN - 1);
    localparam logic [3:0]     WB_END = 4'(WB_LAT);
    localparam logic [5:0]     HALT   = 6'h3F;

    typedef enum logic [1:0] {IDLE, FETCH, RUN, DRAIN} state_t;

    state_t         state_q, state_d;
    logic [IAW-1:0] pc_q, pc_d;
    logic [IAW-1:0] fidx_q, fidx_d;   // ROM index of the word currently on dataI
    logic [3:0]     dcnt_q, dcnt_d;
    logic [DAW-1:0] a_q, a_d, b_q, b_d, w_q, w_d;
    logic [5:0]     op_q, op_d;
    logic           iv_q, iv_d;
    logic           done_q, done_d;
    logic           ovr_q, ovr_d;

    logic [WB_LAT-1:0]          pv_q;
    logic [WB_LAT-1:0]          pwf_q;
    logic [WB_LAT-1:0][DAW-1:0] pw_q;

    logic [5:0]     f_op;
    logic [DAW-1:0] f_a, f_b, f_w;

    assign f_op = dataI[35:30];
    assign f_a  = DAW'(dataI[29:20]);
    assign f_b  = DAW'(dataI[19:10]);
    assign f_w  = DAW'(dataI[9:0]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pc_q    <= '0;
            fidx_q  <= '0;
            dcnt_q  <= '0;
            a_q     <= '0;
            b_q     <= '0;
            w_q     <= '0;
            op_q    <= '0;
            iv_q    <= 1'b0;
            done_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            fidx_q  <= fidx_d;
            dcnt_q  <= dcnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            w_q     <= w_d;
            op_q    <= op_d;
            iv_q    <= iv_d;
            done_q  <= done_d;
            ovr_q   <= ovr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        fidx_d  = fidx_q;
        dcnt_d  = dcnt_q;
        a_d     = '0;
        b_d     = '0;
        w_d     = '0;
        op_d    = '0;
        iv_d    = 1'b0;
        done_d  = 1'b0;

        ovr_d = ovr_q;
        if (overrun_clr)
            ovr_d = 1'b0;
        if (sample_tick && state_q != IDLE)
            ovr_d = 1'b1;

        unique case (state_q)
            IDLE: begin
                if (sample_tick) begin
                    state_d = FETCH;
                    pc_d    = '0;
                end
            end
            FETCH: begin
                state_d = RUN;
                fidx_d  = '0;
                if (pc_q < LAST)
                    pc_d = pc_q + 1'b1;
            end
            RUN: begin
                // The drain counter starts at 1 after HALT because the HALT
                // cycle itself already follows the last issue; after a full
                // program the DRAIN entry cycle is the last issue cycle.
                if (f_op == HALT) begin
                    state_d = DRAIN;
                    dcnt_d  = 4'd1;
                end else begin
                    a_d  = f_a;
                    b_d  = f_b;
                    w_d  = f_w;
                    op_d = f_op;
                    iv_d = 1'b1;
                    if (fidx_q == LAST) begin
                        state_d = DRAIN;
                        dcnt_d  = '0;
                    end else begin
                        fidx_d = fidx_q + 1'b1;
                        if (pc_q < LAST)
                            pc_d = pc_q + 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (dcnt_q == WB_END) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    dcnt_d = dcnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Write pipeline fed from the issue registers; the tail lines up WB_LAT
    // cycles after the issue becomes visible.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pv_q  <= '0;
            pwf_q <= '0;
            pw_q  <= '0;
        end else begin
            pv_q[0]  <= iv_q;
            pwf_q[0] <= op_q[5];
            pw_q[0]  <= w_q;
            for (int unsigned i = 1; i < WB_LAT; i++) begin
                pv_q[i]  <= pv_q[i-1];
                pwf_q[i] <= pwf_q[i-1];
                pw_q[i]  <= pw_q[i-1];
            end
        end
    end

    assign addrI       = pc_q;
    assign addrA       = a_q;
    assign addrB       = b_q;
    assign opcode      = op_q;
    assign issue_valid = iv_q;
    assign writeEn     = pv_q[WB_LAT-1] & pwf_q[WB_LAT-1];
    assign addrW       = pv_q[WB_LAT-1] ? pw_q[WB_LAT-1] : '0;
    assign busy        = (state_q != IDLE);
    assign frame_done  = done_q;
    assign overrun     = ovr_q;

endmodule

// File: tb/tb_dsp_sequencer.sv
// tb_dsp_sequencer
//   Three sequencer instances (PROG_LEN 4, 8, 512) share one ROM image. Each
//   frame's expected waveform is derived from the timing rules: with E issued
//   instructions, instruction k issues at T+k+3, writes at T+k+3+WB_LAT, and
//   frame_done lands at T+E+3+WB_LAT.
module tb_dsp_sequencer;

    localparam int IAW = 9;
    localparam int IWW = 36;
    localparam int DAW = 10;
    localparam int WB  = 3;
    localparam int NI  = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic [NI-1:0] tick;
    logic [NI-1:0] clr;
    logic [IWW-1:0] rom [512];

    logic [NI-1:0][11:0] fetch_v;   // {addrI, busy, frame_done, overrun}
    logic [NI-1:0][26:0] issue_v;   // {issue_valid, opcode, addrA, addrB}
    logic [NI-1:0][10:0] write_v;   // {writeEn, addrW}

    logic [NI-1:0] exp_ovr;
    int checks = 0;
    int errors = 0;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int P = (g == 0) ? 4 : (g == 1) ? 8 : 512;
        logic [IAW-1:0] addrI;
        logic [IWW-1:0] dataI;
        logic [DAW-1:0] addrA, addrB, addrW;
        logic [5:0]     opcode;
        logic           issue_valid, writeEn, busy, frame_done, overrun;

        dsp_sequencer #(.IAW(IAW), .IWW(IWW), .DAW(DAW), .PROG_LEN(P), .WB_LAT(WB)) u_dut (
            .clk(clk), .rst_n(rst_n), .sample_tick(tick[g]),
            .addrI(addrI), .dataI(dataI),
            .addrA(addrA), .addrB(addrB), .opcode(opcode), .issue_valid(issue_valid),
            .addrW(addrW), .writeEn(writeEn), .busy(busy), .frame_done(frame_done),
            .overrun(overrun), .overrun_clr(clr[g])
        );

        always @(posedge clk) dataI <= rom[addrI];

        assign fetch_v[g] = {addrI, busy, frame_done, overrun};
        assign issue_v[g] = {issue_valid, opcode, addrA, addrB};
        assign write_v[g] = {writeEn, addrW};
    end

    function automatic int plen(input int s);
        return (s == 0) ? 4 : (s == 1) ? 8 : 512;
    endfunction

    function automatic logic [IWW-1:0] rand_instr(input bit wr);
        logic [4:0] lo;
        lo = 5'($urandom_range(0, 31));
        if (wr && lo == 5'h1F) lo = 5'h1E;
        return {wr, lo, 10'($urandom), 10'($urandom), 10'($urandom)};
    endfunction

    // Runs one frame on instance s starting with a tick in the current cycle.
    // Returns at the negedge of the frame_done cycle so a caller may tick again.
    task automatic run_frame(input int s, input int ovr_t, input int clr_t,
                             output int nwr, output int peak);
        int P, E, lastf, done, k, kw;
        bit halted;
        logic [11:0] ef;
        logic [26:0] ei;
        logic [10:0] ew;
        logic [IWW-1:0] w;
        P = plen(s);
        E = P;
        halted = 0;
        for (int i = 0; i < P; i++) begin
            w = rom[i];
            if (!halted && w[35:30] == 6'h3F) begin
                E = i;
                halted = 1;
            end
        end
        lastf = halted ? ((E + 1 < P) ? E + 1 : P - 1) : P - 1;
        done = E + 3 + WB;
        nwr = 0;
        peak = 0;
        tick[s] = 1'b1;
        for (int t = 1; t <= done; t++) begin
            @(negedge clk);
            ef = {IAW'((t - 1 < lastf) ? t - 1 : lastf), t < done, t == done, exp_ovr[s]};
            k = t - 3;
            if (k >= 0 && k < E) begin
                w = rom[k];
                ei = {1'b1, w[35:30], w[29:20], w[19:10]};
            end else ei = '0;
            kw = t - 3 - WB;
            if (kw >= 0 && kw < E) begin
                w = rom[kw];
                ew = {w[35], w[9:0]};
            end else ew = '0;
            checks++;
            if (fetch_v[s] !== ef) begin
                errors++;
                $display("FAIL fetch/status inst=%0d t=%0d got=%h expected=%h", s, t, fetch_v[s], ef);
            end
            checks++;
            if (issue_v[s] !== ei) begin
                errors++;
                $display("FAIL issue inst=%0d t=%0d got=%h expected=%h", s, t, issue_v[s], ei);
            end
            checks++;
            if (write_v[s] !== ew) begin
                errors++;
                $display("FAIL write inst=%0d t=%0d got=%h expected=%h", s, t, write_v[s], ew);
            end
            if (write_v[s][10]) nwr++;
            if (int'(fetch_v[s][11:3]) > peak) peak = int'(fetch_v[s][11:3]);
            tick[s] = (t == ovr_t);
            clr[s]  = (t == clr_t);
            if (clr[s]) exp_ovr[s] = 1'b0;
            if (tick[s] && t < done) exp_ovr[s] = 1'b1;
        end
        tick[s] = 1'b0;
        clr[s]  = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        for (int s = 0; s < NI; s++) begin
            checks++;
            if ({fetch_v[s], issue_v[s], write_v[s]} !== '0) begin
                errors++;
                $display("FAIL reset_outputs inst=%0d got=%h expected=0", s, {fetch_v[s], issue_v[s], write_v[s]});
            end
        end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        for (int s = 0; s < NI; s++) begin
            checks++;
            if ({fetch_v[s], issue_v[s], write_v[s]} !== '0) begin
                errors++;
                $display("FAIL idle_after_reset inst=%0d got=%h expected=0", s, {fetch_v[s], issue_v[s], write_v[s]});
            end
        end
    endtask

    task automatic test_full_prog;
        int nwr, peak;
        logic [IWW-1:0] w;
        for (int i = 0; i < 4; i++) begin
            w = rand_instr(1'b1);
            w[9:0] = 10'h010 + 10'(i);
            rom[i] = w;
        end
        run_frame(0, -1, -1, nwr, peak);
        checks++;
        if (nwr != 4 || peak != 3) begin
            errors++;
            $display("FAIL full_prog4 writes=%0d peak=%0d expected 4/3", nwr, peak);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_write_flag;
        int nwr, peak;
        for (int i = 0; i < 4; i++) rom[i] = rand_instr(1'b1);
        rom[1][35:30] = 6'h01;
        run_frame(0, -1, -1, nwr, peak);
        checks++;
        if (nwr != 3) begin
            errors++;
            $display("FAIL write_flag writes=%0d expected 3", nwr);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_halt;
        int nwr, peak;
        for (int i = 0; i < 8; i++) rom[i] = rand_instr(1'b1);
        rom[2][35:30] = 6'h3F;
        run_frame(1, -1, -1, nwr, peak);
        checks++;
        if (nwr != 2 || peak != 3) begin
            errors++;
            $display("FAIL halt_at_2 writes=%0d peak=%0d expected 2/3", nwr, peak);
        end
        repeat (2) @(negedge clk);
        rom[0][35:30] = 6'h3F;
        run_frame(1, -1, -1, nwr, peak);
        checks++;
        if (nwr != 0) begin
            errors++;
            $display("FAIL halt_at_0 writes=%0d expected 0", nwr);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_random_frames;
        int nwr, peak, h;
        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < 8; i++) rom[i] = rand_instr(1'($urandom));
            h = $urandom_range(0, 10);
            if (h < 8) rom[h][35:30] = 6'h3F;
            run_frame(1, -1, -1, nwr, peak);
            repeat ($urandom_range(1, 3)) @(negedge clk);
        end
    endtask

    task automatic test_overrun;
        int nwr, peak;
        for (int i = 0; i < 8; i++) rom[i] = rand_instr(1'($urandom));
        run_frame(1, 5, -1, nwr, peak);
        repeat (2) @(negedge clk);
        run_frame(1, 4, 4, nwr, peak);
        repeat (2) @(negedge clk);
        run_frame(1, -1, 3, nwr, peak);
        repeat (2) @(negedge clk);
        checks++;
        if (fetch_v[1][0] !== 1'b0) begin
            errors++;
            $display("FAIL overrun_cleared got=%b expected=0", fetch_v[1][0]);
        end
    endtask

    task automatic test_reset_midframe;
        int nwr, peak;
        for (int i = 0; i < 8; i++) rom[i] = rand_instr(1'b1);
        tick[1] = 1'b1;
        @(negedge clk);
        tick[1] = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        exp_ovr = '0;
        checks++;
        if ({fetch_v[1], issue_v[1], write_v[1]} !== '0) begin
            errors++;
            $display("FAIL reset_midframe got=%h expected=0", {fetch_v[1], issue_v[1], write_v[1]});
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            checks++;
            if ({fetch_v[1], issue_v[1], write_v[1]} !== '0) begin
                errors++;
                $display("FAIL quiet_after_reset c=%0d got=%h expected=0", c, {fetch_v[1], issue_v[1], write_v[1]});
            end
        end
        run_frame(1, -1, -1, nwr, peak);
        repeat (2) @(negedge clk);
    endtask

    task automatic test_back_to_back;
        int nwr, peak;
        for (int i = 0; i < 8; i++) rom[i] = rand_instr(1'($urandom));
        run_frame(1, -1, -1, nwr, peak);
        run_frame(1, -1, -1, nwr, peak);
        run_frame(1, -1, -1, nwr, peak);
        repeat (2) @(negedge clk);
    endtask

    task automatic test_prog512;
        int nwr, peak;
        for (int i = 0; i < 512; i++) rom[i] = rand_instr(1'b1);
        run_frame(2, -1, -1, nwr, peak);
        checks++;
        if (nwr != 512 || peak != 511) begin
            errors++;
            $display("FAIL prog512 writes=%0d peak=%0d expected 512/511", nwr, peak);
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        rst_n   = 1'b0;
        tick    = '0;
        clr     = '0;
        exp_ovr = '0;
        for (int i = 0; i < 512; i++) rom[i] = rand_instr(1'b0);
        test_reset;
        test_full_prog;
        test_write_flag;
        test_halt;
        test_random_frames;
        test_overrun;
        test_reset_midframe;
        test_back_to_back;
        test_prog512;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/dsp_sequencer.md
# dsp_sequencer

Per-sample program sequencer for the mixer DSP core. On each `sample_tick` it steps the instruction ROM address through the program and decodes each fetched 36-bit word into the read addresses, opcode and delayed write address/enable for the segmented data-memory controller and ALU. It also detects early program end (HALT), drains the write pipeline, and flags sample-rate overruns. It sits between the audio frame timer and the memory controller.

## Interface
- `IAW`, 9: instruction address width.
- `IWW`, 36: instruction word width. Fixed field layout below.
- `DAW`, 10: segmented data address width.
- `PROG_LEN`, 512: maximum instructions per frame, 1..2^IAW.
- `WB_LAT`, 3: cycles from the read-address issue to the matching `writeEn`/`addrW`, 1..8.

Ports:
- `clk` in 1: single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `sample_tick` in 1: one-cycle frame start strobe.
- `addrI` out IAW: instruction ROM address. ROM output is valid one cycle later.
- `dataI` in IWW: ROM word.
- `addrA`, `addrB` out DAW: read addresses, registered.
- `opcode` out 6: opcode to the ALU, aligned with `addrA`/`addrB`.
- `issue_valid` out 1: `addrA`/`addrB`/`opcode` carry a live instruction.
- `addrW` out DAW: write address.
- `writeEn` out 1: write strobe.
- `busy` out 1: frame in progress.
- `frame_done` out 1: one-cycle pulse at frame end.
- `overrun` out 1: sticky overrun flag.
- `overrun_clr` in 1: clears `overrun`.

## Operation
- Instruction fields:
  - `opcode` = `dataI[35:30]`.
  - A = `[29:20]`, B = `[19:10]`, W = `[9:0]`.
  - `opcode[5]` is the write flag.
  - `6'h3F` is HALT. It is never issued.
- States:
  - **IDLE**: `busy`=0. If `sample_tick`=1, set `pc`=0 and go to FETCH.
  - **FETCH**: one priming cycle. `addrI`=0, `busy`=1. Go to RUN.
  - **RUN**: each cycle decodes `dataI` and advances `pc` if `pc`<PROG_LEN-1.
    - Non-HALT word: register its fields into the outputs with `issue_valid`=1.
    - HALT, or issuing index PROG_LEN-1: go to DRAIN. The one fetch already in flight is squashed and never issued.
  - **DRAIN**: `issue_valid`=0. Count WB_LAT cycles after the last issue, then go to IDLE with `frame_done`=1 and `busy`=0 in that same cycle.
- `pc` never wraps. `addrI` holds at its last value until the next FETCH.
- Write pipeline: a WB_LAT-deep shift register of {valid, write flag, W}.
  - `writeEn` = valid & write flag at the tail.
  - `addrW` = the tail's W when valid, else 0.
- Non-issue cycles drive `addrA`=`addrB`=0 and `opcode`=0.
- `sample_tick` handling:
  - In IDLE, including the `frame_done` cycle: starts a frame.
  - In any other state: ignored, and `overrun` is set the next cycle.
- `overrun_clr` clears `overrun`. If set and clear occur together, set wins.
- Reset (asynchronous, any state): state=IDLE, `pc`=0, pipeline flushed. All outputs are 0: `addrI`, `addrA`, `addrB`, `opcode`, `issue_valid`, `addrW`, `writeEn`, `busy`, `frame_done`, `overrun`. Reset mid-frame aborts with no further writes and no `frame_done`.

## Timing
- Frame start, with tick in cycle T:
  - T+1: `addrI`=0, `busy`=1.
  - T+k+1: `addrI`=k.
  - T+k+3: instruction k is issued.
  - T+k+3+WB_LAT: its write.
- Full program of N instructions:
  - Last issue at T+N+2.
  - Last write at T+N+2+WB_LAT.
  - `frame_done` at T+N+3+WB_LAT.
- HALT at index h: last issue is instruction h-1 at T+h+2. `frame_done` at T+h+3+WB_LAT. With h=0 there are no issues or writes, and `frame_done` comes at T+3+WB_LAT.
- Minimum frame period: N+3+WB_LAT cycles. A tick in the `frame_done` cycle is accepted without overrun.

## Test plan
- PROG_LEN=4, WB_LAT=3, four write instructions with W=0x010..0x013, tick at T:
  - `addrI` 0..3 at T+1..T+4.
  - `issue_valid` T+3..T+6.
  - `writeEn` T+6..T+9 with `addrW` 0x010..0x013.
  - `frame_done` at T+10.
- PROG_LEN=8, HALT at index 2:
  - Only instructions 0 and 1 issue.
  - ROM[3] is fetched but never issued.
  - `frame_done` at T+8. No `writeEn` after T+7.
- Write flag clear (opcode 0x01) on instruction 1: its issue slot has `issue_valid`=1, and `writeEn` stays 0 three cycles later.
- Overrun:
  - Tick at T+5 mid-frame: frame timing unchanged, `overrun`=1 at T+6.
  - `overrun_clr` plus a new overrun tick in the same cycle: `overrun` stays 1. `overrun_clr` alone: 0 next cycle.
- `rst_n` low at T+5 mid-frame: all outputs read 0 immediately. After release, nothing happens until the next tick, then a full frame runs.
- Tick in the `frame_done` cycle: `addrI`=0 the next cycle, `overrun` stays 0. Also run PROG_LEN=512: `addrI` peaks at 511 and exactly 512 writes occur.
